// File: rtl/twos_comp_pkg.sv
// rtl/twos_comp_pkg.sv - shared state and mode encodings for the bit-serial two's-complement converter
package twos_comp_pkg;

    // Controller states: wait for a word, walk its bits, hold the result.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // in_mode encodings.
    localparam logic MODE_NEG = 1'b0;
    localparam logic MODE_ABS = 1'b1;

    // Width of a counter that must reach WIDTH-1.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/twos_comp_bit_cell.sv
// rtl/twos_comp_bit_cell.sv - per-bit copy-until-first-one-then-invert rule
module twos_comp_bit_cell (
    input  logic b,
    input  logic do_neg,
    input  logic seen_one,
    output logic out_bit,
    output logic next_seen_one
);

    // Bits up to and including the first 1 pass through; later bits flip when negating.
    assign out_bit       = b ^ (do_neg & seen_one);
    assign next_seen_one = seen_one | b;

endmodule

// File: rtl/twos_comp_serial.sv
// rtl/twos_comp_serial.sv - bit-serial negate/abs converter; TWOS_COMP_SATURATE_EN clamps overflow to max positive
module twos_comp_serial
    import twos_comp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);

    localparam int               CNT_W   = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

    state_t           state_q;
    logic [WIDTH-1:0] src_q;
    logic [WIDTH-1:0] res_q;
    logic [CNT_W-1:0] cnt_q;
    logic             seen_one_q;
    logic             do_neg_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_ovf_q;

    logic             cell_bit;
    logic             seen_one_d;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] final_d;
    logic             accept;
    logic             do_neg_d;

    twos_comp_bit_cell u_cell (
        .b             (src_q[0]),
        .do_neg        (do_neg_q),
        .seen_one      (seen_one_q),
        .out_bit       (cell_bit),
        .next_seen_one (seen_one_d)
    );

    // Result bits enter at the MSB so the word is LSB-aligned after WIDTH shifts.
    always_comb begin
        res_d    = {cell_bit, res_q[WIDTH-1:1]};
        accept   = in_valid & in_ready_q;
        do_neg_d = (in_mode == MODE_NEG) | in_data[WIDTH-1];
    end

`ifdef TWOS_COMP_SATURATE_EN
    // Negating the most negative value clamps to the most positive one.
    assign final_d = ovf_q ? MAX_POS : res_d;
`else
    // Negating the most negative value wraps back to itself.
    assign final_d = res_d;
`endif

    // Controller: accept a word, walk it one bit per cycle, hold the result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            src_q       <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            seen_one_q  <= 1'b0;
            do_neg_q    <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        src_q      <= in_data;
                        do_neg_q   <= do_neg_d;
                        ovf_q      <= do_neg_d & (in_data == MIN_NEG);
                        cnt_q      <= '0;
                        seen_one_q <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    src_q      <= src_q >> 1;
                    res_q      <= res_d;
                    seen_one_q <= seen_one_d;
                    cnt_q      <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        out_data_q  <= final_d;
                        out_ovf_q   <= ovf_q;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_twos_comp_serial.sv
// tb/tb_twos_comp_serial.sv - self-checking bench for twos_comp_serial at WIDTH 4 and 8
module tb_twos_comp_serial;
    import twos_comp_pkg::*;

    logic clk;
    logic rst;

    logic       in_valid4, in_ready4, in_mode4, out_valid4, out_ready4, out_ovf4;
    logic [3:0] in_data4, out_data4;
    logic       in_valid8, in_ready8, in_mode8, out_valid8, out_ready8, out_ovf8;
    logic [7:0] in_data8, out_data8;

    twos_comp_serial #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_mode(in_mode4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4), .out_ovf(out_ovf4)
    );

    twos_comp_serial #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .in_mode(in_mode8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8), .out_ovf(out_ovf8)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       o;
    } exp_t;

    typedef struct {
        logic [3:0] din;
        logic       mode;
        logic [3:0] dout;
        logic       ovf;
    } vec_t;

    exp_t q4[$];
    exp_t q8[$];
    int   checks = 0;
    int   errors = 0;

`ifdef TWOS_COMP_SATURATE_EN
    localparam logic [3:0] OVF_OUT4 = 4'b0111;
    localparam logic [7:0] OVF_OUT8 = 8'h7F;
`else
    localparam logic [3:0] OVF_OUT4 = 4'b1000;
    localparam logic [7:0] OVF_OUT8 = 8'h80;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Arithmetic reference for WIDTH=8 results.
    function automatic exp_t model8(input logic [7:0] d, input logic m);
        exp_t e;
        logic neg;
        neg = (m == MODE_NEG) || d[7];
        e.d = neg ? (8'd0 - d) : d;
        e.o = neg && (d == 8'h80);
        if (e.o) e.d = OVF_OUT8;
        return e;
    endfunction

    // Scoreboard for the 4-bit instance.
    always @(negedge clk) begin
        if (!rst && out_valid4 && out_ready4) begin
            if (q4.size() == 0) begin
                check("unexpected_out4", 32'(out_data4), 32'hDEAD);
            end else begin
                exp_t e;
                e = q4.pop_front();
                check("out_data4", 32'(out_data4), 32'(e.d));
                check("out_ovf4", 32'(out_ovf4), 32'(e.o));
            end
        end
    end

    // Scoreboard for the 8-bit instance.
    always @(negedge clk) begin
        if (!rst && out_valid8 && out_ready8) begin
            if (q8.size() == 0) begin
                check("unexpected_out8", 32'(out_data8), 32'hDEAD);
            end else begin
                exp_t e;
                e = q8.pop_front();
                check("out_data8", 32'(out_data8), 32'(e.d));
                check("out_ovf8", 32'(out_ovf8), 32'(e.o));
            end
        end
    end

    task automatic send4(input logic [3:0] d, input logic m, input logic [3:0] ed, input logic eo);
        int n;
        n = 0;
        while (!in_ready4 && n < 100) begin @(negedge clk); n++; end
        if (!in_ready4) begin check("send4_timeout", 0, 1); return; end
        q4.push_back({4'h0, ed, eo});
        in_valid4 = 1'b1; in_data4 = d; in_mode4 = m;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
    endtask

    task automatic send8(input logic [7:0] d, input logic m, input logic push, input exp_t e);
        int n;
        n = 0;
        while (!in_ready8 && n < 100) begin @(negedge clk); n++; end
        if (!in_ready8) begin check("send8_timeout", 0, 1); return; end
        if (push) q8.push_back(e);
        in_valid8 = 1'b1; in_data8 = d; in_mode8 = m;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q4.size() != 0 || q8.size() != 0) && n < 500) begin @(posedge clk); #1; n++; end
        check("drain_q4", q4.size(), 0);
        check("drain_q8", q8.size(), 0);
    endtask

    task automatic wait_valid8(input string name);
        int n;
        n = 0;
        while (!out_valid8 && n < 100) begin @(posedge clk); #1; n++; end
        check(name, 32'(out_valid8), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[10];
        logic [7:0] words[3];
        exp_t       none;
        int         edges, cyc, last_acc, idx;
        logic       acc;

        none = '0;
        tbl[0] = '{4'b0011, MODE_NEG, 4'b1101, 1'b0};
        tbl[1] = '{4'b0111, MODE_NEG, 4'b1001, 1'b0};
        tbl[2] = '{4'b1011, MODE_NEG, 4'b0101, 1'b0};
        tbl[3] = '{4'b1100, MODE_ABS, 4'b0100, 1'b0};
        tbl[4] = '{4'b0111, MODE_ABS, 4'b0111, 1'b0};
        tbl[5] = '{4'b1001, MODE_ABS, 4'b0111, 1'b0};
        tbl[6] = '{4'b0000, MODE_ABS, 4'b0000, 1'b0};
        tbl[7] = '{4'b0000, MODE_NEG, 4'b0000, 1'b0};
        tbl[8] = '{4'b1000, MODE_NEG, OVF_OUT4, 1'b1};
        tbl[9] = '{4'b1000, MODE_ABS, OVF_OUT4, 1'b1};

        rst = 1'b1;
        in_valid4 = 0; in_data4 = 0; in_mode4 = 0; out_ready4 = 1;
        in_valid8 = 0; in_data8 = 0; in_mode8 = 0; out_ready8 = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready4", 32'(in_ready4), 1);
        check("rst_out_valid4", 32'(out_valid4), 0);
        check("rst_out_data4", 32'(out_data4), 0);
        check("rst_out_ovf4", 32'(out_ovf4), 0);
        check("rst_in_ready8", 32'(in_ready8), 1);
        check("rst_out_valid8", 32'(out_valid8), 0);
        check("rst_out_data8", 32'(out_data8), 0);
        check("rst_out_ovf8", 32'(out_ovf8), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Table of 4-bit vectors.
        for (int i = 0; i < 10; i++) send4(tbl[i].din, tbl[i].mode, tbl[i].dout, tbl[i].ovf);
        drain();

        // Latency: accept edge plus WIDTH shift edges.
        send4(4'b0011, MODE_NEG, 4'b1101, 1'b0);
        edges = 1;
        while (!out_valid4 && edges < 50) begin @(posedge clk); #1; edges++; end
        check("latency4_edges", edges, 5);
        drain();

        // Backpressure on the 8-bit instance.
        out_ready8 = 1'b0;
        send8(8'h01, MODE_NEG, 1'b1, '{8'hFF, 1'b0});
        wait_valid8("bp_valid");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_data", 32'(out_data8), 32'hFF);
            check("bp_hold_valid", 32'(out_valid8), 1);
            check("bp_in_ready", 32'(in_ready8), 0);
        end
        @(posedge clk); #1;
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        check("bp_in_ready_back", 32'(in_ready8), 1);
        check("bp_valid_drop", 32'(out_valid8), 0);
        send8(8'h80, MODE_NEG, 1'b1, '{OVF_OUT8, 1'b1});
        drain();

        // Reset during SHIFT discards the word.
        send8(8'h35, MODE_NEG, 1'b0, none);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready8), 1);
        check("midrst_out_valid", 32'(out_valid8), 0);
        check("midrst_out_data", 32'(out_data8), 0);
        send8(8'h35, MODE_NEG, 1'b1, '{8'hCB, 1'b0});
        drain();

        // Reset while DONE holds a result.
        out_ready8 = 1'b0;
        send8(8'h35, MODE_NEG, 1'b0, none);
        wait_valid8("donerst_valid");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("donerst_out_valid", 32'(out_valid8), 0);
        check("donerst_in_ready", 32'(in_ready8), 1);
        out_ready8 = 1'b1;

        // Back-to-back stream with in_valid held and bus noise while busy.
        words[0] = 8'h01; words[1] = 8'h7F; words[2] = 8'h00;
        idx = 0; cyc = 0; last_acc = 0;
        in_data8 = words[0]; in_mode8 = MODE_NEG; in_valid8 = 1'b1;
        while (idx < 3 && cyc < 200) begin
            @(negedge clk);
            acc = in_ready8 && in_valid8;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                q8.push_back(model8(words[idx], MODE_NEG));
                if (idx > 0) check("b2b_spacing", cyc - last_acc, 10);
                last_acc = cyc;
                idx++;
            end
            if (idx < 3) begin
                if (in_ready8) begin
                    in_data8 = words[idx]; in_mode8 = MODE_NEG;
                end else begin
                    in_data8 = 8'($urandom); in_mode8 = 1'($urandom);
                end
            end
        end
        in_valid8 = 1'b0;
        check("b2b_count", idx, 3);
        check("b2b_results_expected", (model8(8'h7F, MODE_NEG).d == 8'h81) ? 1 : 0, 1);
        drain();

        // Random words through the 8-bit instance.
        for (int i = 0; i < 20; i++) begin
            logic [7:0] d;
            logic       m;
            d = 8'($urandom);
            m = 1'($urandom);
            send8(d, m, 1'b1, model8(d, m));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
